// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
//
// APB4-style master that turns single requests from the JTAG-side requester
// into APB transfers on one of NUM_SLAVES slaves. The slave index is decoded
// from apb_paddr[SEL_LSB +: SEL_W]. The bridge runs IDLE -> SETUP -> ACCESS
// and reports completion, read data and errors back to the requester.
//
// Optional feature (macro APB_MASTER_PSTRB_EN):
//   defined   : adds apb_write_strb input and pstrb output; a write whose
//               strobe is all zero is rejected as an illegal request.
//   undefined : no strobe ports; every write is full width.
//
// Ports:
//   pclock, presetn          clock, synchronous active-low reset
//   transfer, read, write    request strobe and direction
//   apb_paddr, apb_write_data request address / write data
//   apb_busy                 high while a transfer is in SETUP/ACCESS
//   psel, penable, pwrite,
//   paddr, pwdata            APB master outputs
//   prdata, pready, pslverr  packed per-slave APB responses
//   apb_read_data_out        last captured read data
//   apb_read_data_valid      1-cycle pulse: read completed
//   apb_write_done           1-cycle pulse: write completed
//   apb_err                  1-cycle pulse: slave error, timeout,
//                            decode error or illegal request
//   fsm_state                current FSM state (debug visibility)
//
// Request handshake: the requester presents transfer=1 with the request
// fields for one cycle. The request is taken when apb_busy=0 at that edge;
// while apb_busy=1 requests are ignored, not queued. Every accepted or
// rejected request produces exactly one result pulse (valid, done and/or
// err), except when cut short by reset.
// ----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclock,
    input  logic                             presetn,
    input  logic                             transfer,
    input  logic                             read,
    input  logic                             write,
    input  logic [ADDR_WIDTH-1:0]            apb_paddr,
    input  logic [DATA_WIDTH-1:0]            apb_write_data,
`ifdef APB_MASTER_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]          apb_write_strb,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
`endif
    output logic                             apb_busy,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr,
    output logic [DATA_WIDTH-1:0]            apb_read_data_out,
    output logic                             apb_read_data_valid,
    output logic                             apb_write_done,
    output logic                             apb_err,
    output logic [1:0]                       fsm_state
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state_q,  state_d;
    logic [SEL_W-1:0]      idx_q,    idx_d;
    logic [ADDR_WIDTH-1:0] paddr_q,  paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wdone_q,  wdone_d;
    logic                  err_q,    err_d;
`ifdef APB_MASTER_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
`endif

    // Request qualification
    logic [SEL_W-1:0] req_idx;
    logic             dec_ok;
    logic             dir_ok;
    logic             strb_ok;
    logic             req_ok;

    assign req_idx = apb_paddr[SEL_LSB +: SEL_W];
    // Index field may encode more values than there are slaves.
    assign dec_ok  = (int'(req_idx) < NUM_SLAVES);
    assign dir_ok  = read ^ write;
`ifdef APB_MASTER_PSTRB_EN
    assign strb_ok = read || (apb_write_strb != '0);
`else
    assign strb_ok = 1'b1;
`endif
    assign req_ok  = dir_ok && strb_ok && dec_ok;

    // Response mux: only the selected slave's pready/pslverr/prdata matter.
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot select, active only in SETUP/ACCESS.
    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel[i] = (state_q != ST_IDLE) && (idx_q == SEL_W'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        err_d    = 1'b0;
`ifdef APB_MASTER_PSTRB_EN
        pstrb_d  = pstrb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    if (req_ok) begin
                        state_d  = ST_SETUP;
                        idx_d    = req_idx;
                        paddr_d  = apb_paddr;
                        pwrite_d = write;
                        pwdata_d = apb_write_data;
`ifdef APB_MASTER_PSTRB_EN
                        pstrb_d  = write ? apb_write_strb : '0;
`endif
                    end else begin
                        // Rejected request: report it, leave the bus alone.
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_d = ST_IDLE;
                    err_d   = sel_err;
                    if (pwrite_q) begin
                        wdone_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = sel_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th ACCESS cycle without
                    // pready: give up, keep the old read data.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclock) begin
        if (!presetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef APB_MASTER_PSTRB_EN
            pstrb_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            err_q    <= err_d;
`ifdef APB_MASTER_PSTRB_EN
            pstrb_q  <= pstrb_d;
`endif
        end
    end

    assign apb_busy            = (state_q != ST_IDLE);
    assign penable             = (state_q == ST_ACCESS);
    assign pwrite              = pwrite_q;
    assign paddr               = paddr_q;
    assign pwdata              = pwdata_q;
    assign apb_read_data_out   = rdata_q;
    assign apb_read_data_valid = rvalid_q;
    assign apb_write_done      = wdone_q;
    assign apb_err             = err_q;
    assign fsm_state           = state_q;
`ifdef APB_MASTER_PSTRB_EN
    assign pstrb               = pstrb_q;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// Directed bench for apb_master_bridge. A 4-slave instance carries the main
// scenarios; a 3-slave instance covers the out-of-range index decode.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;

    logic         pclock;
    logic         presetn;

    // 4-slave instance
    logic         transfer, read, write;
    logic [31:0]  apb_paddr, apb_write_data;
    logic         apb_busy, penable, pwrite;
    logic [3:0]   psel;
    logic [31:0]  paddr, pwdata;
    logic [127:0] prdata;
    logic [3:0]   pready, pslverr;
    logic [31:0]  apb_read_data_out;
    logic         apb_read_data_valid, apb_write_done, apb_err;
    logic [1:0]   fsm_state;
`ifdef APB_MASTER_PSTRB_EN
    logic [3:0]   apb_write_strb, pstrb;
    logic [3:0]   t3_strb, pstrb3;
`endif

    // 3-slave instance
    logic         t3_transfer, t3_read, t3_write;
    logic [31:0]  t3_addr;
    logic         busy3, penable3, pwrite3;
    logic [2:0]   psel3;
    logic [31:0]  paddr3, pwdata3;
    logic [95:0]  prdata3;
    logic [2:0]   pready3, pslverr3;
    logic [31:0]  rdata3;
    logic         valid3, done3, err3;
    logic [1:0]   state3;

    int n_tests = 0;
    int n_fail  = 0;

    apb_master_bridge #(.NUM_SLAVES(4)) u_dut (
        .pclock(pclock), .presetn(presetn),
        .transfer(transfer), .read(read), .write(write),
        .apb_paddr(apb_paddr), .apb_write_data(apb_write_data),
`ifdef APB_MASTER_PSTRB_EN
        .apb_write_strb(apb_write_strb), .pstrb(pstrb),
`endif
        .apb_busy(apb_busy), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .apb_read_data_out(apb_read_data_out),
        .apb_read_data_valid(apb_read_data_valid),
        .apb_write_done(apb_write_done), .apb_err(apb_err),
        .fsm_state(fsm_state)
    );

    apb_master_bridge #(.NUM_SLAVES(3)) u_dut3 (
        .pclock(pclock), .presetn(presetn),
        .transfer(t3_transfer), .read(t3_read), .write(t3_write),
        .apb_paddr(t3_addr), .apb_write_data(32'h0),
`ifdef APB_MASTER_PSTRB_EN
        .apb_write_strb(t3_strb), .pstrb(pstrb3),
`endif
        .apb_busy(busy3), .psel(psel3), .penable(penable3), .pwrite(pwrite3),
        .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3), .apb_read_data_out(rdata3),
        .apb_read_data_valid(valid3), .apb_write_done(done3), .apb_err(err3),
        .fsm_state(state3)
    );

    // Clock / reset
    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pclock);
    endtask

    task automatic req_write(input logic [31:0] a, input logic [31:0] d);
        transfer       = 1'b1;
        read           = 1'b0;
        write          = 1'b1;
        apb_paddr      = a;
        apb_write_data = d;
    endtask

    task automatic req_read(input logic [31:0] a);
        transfer  = 1'b1;
        read      = 1'b1;
        write     = 1'b0;
        apb_paddr = a;
    endtask

    task automatic req_clear();
        transfer = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
    endtask

    int bad_cycles;

    initial begin
        presetn        = 1'b0;
        transfer       = 1'b0;
        read           = 1'b0;
        write          = 1'b0;
        apb_paddr      = '0;
        apb_write_data = '0;
        pready         = '0;
        pslverr        = '0;
        prdata         = {32'hCAFEF00D, 32'h22222222, 32'h12345678, 32'h0BAD0000};
        t3_transfer    = 1'b0;
        t3_read        = 1'b0;
        t3_write       = 1'b0;
        t3_addr        = '0;
        prdata3        = {32'h33330002, 32'h33330001, 32'h33330000};
        pready3        = 3'b111;
        pslverr3       = 3'b000;
`ifdef APB_MASTER_PSTRB_EN
        apb_write_strb = 4'hF;
        t3_strb        = 4'hF;
`endif

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("rst_psel",    64'(psel), 64'h0);
        check("rst_penable", 64'(penable), 64'h0);
        check("rst_busy",    64'(apb_busy), 64'h0);
        check("rst_paddr",   64'(paddr), 64'h0);
        check("rst_pwdata",  64'(pwdata), 64'h0);
        check("rst_rdata",   64'(apb_read_data_out), 64'h0);
        check("rst_pulses",  64'({apb_read_data_valid, apb_write_done, apb_err}), 64'h0);
        check("rst_state",   64'(fsm_state), 64'h0);
        check("rst_psel3",   64'(psel3), 64'h0);
        presetn = 1'b1;
        cyc();

        // ---------------- T1: write idx 2 ----------------
        req_write(32'h0000_2010, 32'hDEADBEEF);
        pready = 4'b0100;
        cyc();  // SETUP
        req_clear();
        check("t1_setup_psel",    64'(psel), 64'h4);
        check("t1_setup_penable", 64'(penable), 64'h0);
        check("t1_setup_state",   64'(fsm_state), 64'h1);
        check("t1_setup_busy",    64'(apb_busy), 64'h1);
        check("t1_paddr",         64'(paddr), 64'h2010);
        check("t1_pwrite",        64'(pwrite), 64'h1);
        check("t1_pwdata",        64'(pwdata), 64'hDEADBEEF);
`ifdef APB_MASTER_PSTRB_EN
        check("t1_pstrb",         64'(pstrb), 64'hF);
`endif
        cyc();  // ACCESS
        check("t1_access_psel",    64'(psel), 64'h4);
        check("t1_access_penable", 64'(penable), 64'h1);
        check("t1_access_state",   64'(fsm_state), 64'h2);
        check("t1_access_pwdata",  64'(pwdata), 64'hDEADBEEF);
        cyc();  // completion pulse cycle
        check("t1_done_psel",    64'(psel), 64'h0);
        check("t1_done_penable", 64'(penable), 64'h0);
        check("t1_done_pulse",   64'(apb_write_done), 64'h1);
        check("t1_done_err",     64'(apb_err), 64'h0);
        check("t1_done_valid",   64'(apb_read_data_valid), 64'h0);
        check("t1_done_busy",    64'(apb_busy), 64'h0);
        cyc();
        check("t1_done_clear", 64'(apb_write_done), 64'h0);

        // ---------------- T2: read idx 1, 3 wait states ----------------
        req_read(32'h0000_1004);
        pready  = 4'b1101;  // other slaves ready: must be ignored
        pslverr = 4'b0001;  // unselected slave error: must be ignored
        cyc();  // SETUP
        req_clear();
        check("t2_setup_psel",   64'(psel), 64'h2);
        check("t2_setup_pwrite", 64'(pwrite), 64'h0);
        bad_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();  // ACCESS k+1
            if (penable !== 1'b1 || psel !== 4'b0010 || paddr !== 32'h1004 ||
                apb_read_data_valid !== 1'b0 || apb_err !== 1'b0)
                bad_cycles++;
            if (k == 3) pready = 4'b0010;
        end
        check("t2_access_4cyc", 64'(bad_cycles), 64'h0);
        cyc();
        check("t2_valid",     64'(apb_read_data_valid), 64'h1);
        check("t2_rdata",     64'(apb_read_data_out), 64'h12345678);
        check("t2_err",       64'(apb_err), 64'h0);
        check("t2_idle_psel", 64'(psel), 64'h0);
        cyc();
        check("t2_valid_clear", 64'(apb_read_data_valid), 64'h0);
        check("t2_rdata_hold",  64'(apb_read_data_out), 64'h12345678);

        // ---------------- T3: read idx 3 with slave error, then back-to-back write ----------------
        req_read(32'h0000_3000);
        pready  = 4'b1000;
        pslverr = 4'b1000;
        cyc();  // SETUP
        req_clear();
        check("t3_setup_psel", 64'(psel), 64'h8);
        cyc();  // ACCESS
        check("t3_access_penable", 64'(penable), 64'h1);
        cyc();  // completion pulse cycle
        check("t3_valid", 64'(apb_read_data_valid), 64'h1);
        check("t3_err",   64'(apb_err), 64'h1);
        check("t3_rdata", 64'(apb_read_data_out), 64'hCAFEF00D);
        req_write(32'h0000_0008, 32'h0000_00A5);
        pready  = 4'b0001;
        pslverr = 4'b0000;
        cyc();  // request taken in pulse cycle -> SETUP now
        req_clear();
        check("t3b_setup_psel", 64'(psel), 64'h1);
        check("t3b_pulses_clr", 64'({apb_read_data_valid, apb_err}), 64'h0);
        cyc();  // ACCESS
        cyc();
        check("t3b_done",   64'(apb_write_done), 64'h1);
        check("t3b_pwdata", 64'(pwdata), 64'hA5);
        check("t3b_err",    64'(apb_err), 64'h0);

        // ---------------- T4: timeout on idx 0 ----------------
        cyc();
        req_read(32'h0000_0000);
        pready = 4'b1110;  // slave 0 never ready
        cyc();  // SETUP
        req_clear();
        check("t4_setup_psel", 64'(psel), 64'h1);
        bad_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (penable !== 1'b1 || psel !== 4'b0001 || apb_err !== 1'b0) bad_cycles++;
        end
        check("t4_access_16cyc", 64'(bad_cycles), 64'h0);
        cyc();
        check("t4_err",   64'(apb_err), 64'h1);
        check("t4_valid", 64'(apb_read_data_valid), 64'h0);
        check("t4_psel",  64'(psel), 64'h0);
        check("t4_busy",  64'(apb_busy), 64'h0);
        check("t4_rdata", 64'(apb_read_data_out), 64'hCAFEF00D);
        cyc();
        check("t4_err_clear", 64'(apb_err), 64'h0);

        // ---------------- T5: illegal requests and decode error ----------------
        pready = 4'b1111;
        transfer  = 1'b1;
        read      = 1'b1;
        write     = 1'b1;
        apb_paddr = 32'h0000_2000;
        cyc();
        req_clear();
        check("t5_both_err",  64'(apb_err), 64'h1);
        check("t5_both_psel", 64'(psel), 64'h0);
        check("t5_both_busy", 64'(apb_busy), 64'h0);
        transfer = 1'b1;
        cyc();
        req_clear();
        check("t5_none_err",  64'(apb_err), 64'h1);
        check("t5_none_psel", 64'(psel), 64'h0);
        cyc();
        check("t5_err_clear", 64'(apb_err), 64'h0);

        t3_transfer = 1'b1;
        t3_read     = 1'b1;
        t3_addr     = 32'h0000_3000;  // index 3 on a 3-slave bridge
        cyc();
        t3_transfer = 1'b0;
        check("t5_dec_err",  64'(err3), 64'h1);
        check("t5_dec_psel", 64'(psel3), 64'h0);
        check("t5_dec_busy", 64'(busy3), 64'h0);
        cyc();
        check("t5_dec_psel2", 64'(psel3), 64'h0);
        t3_transfer = 1'b1;
        t3_addr     = 32'h0000_2000;  // index 2 is legal
        cyc();
        t3_transfer = 1'b0;
        t3_read     = 1'b0;
        check("t5_ok3_psel", 64'(psel3), 64'h4);
        cyc();
        cyc();
        check("t5_ok3_valid", 64'(valid3), 64'h1);
        check("t5_ok3_rdata", 64'(rdata3), 64'h33330002);
        check("t5_ok3_err",   64'(err3), 64'h0);

        // ---------------- T6: reset during ACCESS ----------------
        req_write(32'h0000_2020, 32'h0000_0001);
        pready = 4'b0000;
        cyc();  // SETUP
        req_clear();
        cyc();  // ACCESS
        check("t6_access_penable", 64'(penable), 64'h1);
        presetn = 1'b0;
        cyc();
        presetn = 1'b1;
        check("t6_rst_psel",    64'(psel), 64'h0);
        check("t6_rst_penable", 64'(penable), 64'h0);
        check("t6_rst_busy",    64'(apb_busy), 64'h0);
        check("t6_rst_pulses",  64'({apb_read_data_valid, apb_write_done, apb_err}), 64'h0);
        cyc();
        check("t6_post_pulses", 64'({apb_read_data_valid, apb_write_done, apb_err}), 64'h0);
        check("t6_post_state",  64'(fsm_state), 64'h0);
        req_write(32'h0000_1040, 32'h55AA55AA);
        pready = 4'b0010;
        cyc();  // SETUP
        req_clear();
        check("t6_w_setup_psel", 64'(psel), 64'h2);
        cyc();  // ACCESS
        check("t6_w_access_penable", 64'(penable), 64'h1);
        cyc();
        check("t6_w_done",   64'(apb_write_done), 64'h1);
        check("t6_w_pwdata", 64'(pwdata), 64'h55AA55AA);
        check("t6_w_paddr",  64'(paddr), 64'h1040);
        check("t6_w_err",    64'(apb_err), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
